// File: rtl/board_pkg.sv
// Shared board geometry, colour codes and arbiter enums for the playfield RAM.
package board_pkg;

  localparam int COLS        = 10;
  localparam int ROWS        = 20;
  localparam int CELL_W      = 3;
  localparam int ADDR_W      = 8;
  localparam int BOARD_CELLS = COLS * ROWS;

  typedef enum logic [CELL_W-1:0] {
    EMPTY  = 3'd0,
    CYAN   = 3'd1,
    BLUE   = 3'd2,
    ORANGE = 3'd3,
    YELLOW = 3'd4,
    GREEN  = 3'd5,
    PURPLE = 3'd6,
    RED    = 3'd7
  } cell_t;

  typedef enum logic [1:0] {
    CL_IDLE = 2'd0,
    CL_RUN  = 2'd1,
    CL_DONE = 2'd2
  } cl_state_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_GAME = 2'd2
  } tag_t;

  // Compared one bit wider so a full 2**ADDR_W board does not wrap to zero.
  function automatic logic addr_legal(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < (ADDR_W + 1)'(BOARD_CELLS));
  endfunction

endpackage

// File: rtl/board_addr.sv
// Cell index row*COLS+col as a shift-add, truncated to ADDR_W bits.
module board_addr
  import board_pkg::*;
(
  input  logic [9:0]        row,
  input  logic [9:0]        col,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [9:0] COLS_V = 10'(COLS);

  logic [19:0] acc_s;
  logic        unused_s;

  // Sum shifted copies of the row for each set bit of COLS, then add the column.
  always_comb begin
    acc_s = 20'd0;
    for (int i = 0; i < 10; i++) begin
      if (COLS_V[i]) begin
        acc_s = acc_s + ({10'd0, row} << i);
      end else begin
        acc_s = acc_s;
      end
    end
    acc_s = acc_s + {10'd0, col};
  end

  assign addr     = acc_s[ADDR_W-1:0];
  assign unused_s = ^acc_s[19:ADDR_W];

endmodule

// File: rtl/board_mem_arbiter.sv
// Playfield RAM arbiter: display scan owns active video, then the clear sweep,
// then game read/write requests, one registered RAM access per cycle.
module board_mem_arbiter
  import board_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              in_display,
  input  logic [9:0]        count_x,
  input  logic [9:0]        count_y,
  output logic [CELL_W-1:0] pixel_cell,
  output logic              pixel_valid,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [CELL_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [CELL_W-1:0] rsp_rdata,
  output logic              req_err,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [CELL_W-1:0] mem_wdata,
  input  logic [CELL_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(BOARD_CELLS - 1);

  logic [ADDR_W-1:0] disp_addr_s;
  logic              accept_s;
  logic              legal_s;

  cl_state_t         cl_state_r;
  logic [ADDR_W-1:0] clear_ptr_r;
  logic              clear_busy_r;
  logic              clear_done_r;

  logic              mem_en_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [CELL_W-1:0] mem_wdata_r;

  // tag0 travels with the issued access, tag1 lines up with mem_rdata
  tag_t              tag0_r;
  tag_t              tag1_r;
  logic              ill0_r;
  logic              ill1_r;

  logic              pixel_valid_r;
  logic [CELL_W-1:0] pixel_cell_r;
  logic              rsp_valid_r;
  logic [CELL_W-1:0] rsp_rdata_r;
  logic              req_err_r;

  board_addr u_disp_addr (
    .row  (count_y),
    .col  (count_x),
    .addr (disp_addr_s)
  );

  assign req_ready = !in_display && !clear_busy_r && !reset;
  assign accept_s  = req_valid && req_ready;
  assign legal_s   = addr_legal(req_addr);

  // Clear sequencer: sweep zeros across the board using blanking slots only.
  always_ff @(posedge clock) begin
    if (reset) begin
      cl_state_r   <= CL_IDLE;
      clear_ptr_r  <= '0;
      clear_busy_r <= 1'b0;
      clear_done_r <= 1'b0;
    end else begin
      case (cl_state_r)
        CL_IDLE: begin
          clear_done_r <= 1'b0;
          if (clear_start) begin
            cl_state_r   <= CL_RUN;
            clear_ptr_r  <= '0;
            clear_busy_r <= 1'b1;
          end
        end
        CL_RUN: begin
          if (!in_display) begin
            clear_ptr_r <= clear_ptr_r + ADDR_W'(1);
            if (clear_ptr_r == LAST_CELL) begin
              cl_state_r   <= CL_DONE;
              clear_busy_r <= 1'b0;
              clear_done_r <= 1'b1;
            end
          end
        end
        CL_DONE: begin
          cl_state_r   <= CL_IDLE;
          clear_done_r <= 1'b0;
        end
        default: begin
          cl_state_r   <= CL_IDLE;
          clear_busy_r <= 1'b0;
          clear_done_r <= 1'b0;
        end
      endcase
    end
  end

  // Slot owner issues the RAM access; two-stage tag pipeline routes read data.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_en_r      <= 1'b0;
      mem_we_r      <= 1'b0;
      mem_addr_r    <= '0;
      mem_wdata_r   <= EMPTY;
      tag0_r        <= TAG_NONE;
      tag1_r        <= TAG_NONE;
      ill0_r        <= 1'b0;
      ill1_r        <= 1'b0;
      req_err_r     <= 1'b0;
      pixel_valid_r <= 1'b0;
      pixel_cell_r  <= EMPTY;
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= EMPTY;
    end else begin
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= EMPTY;
      tag0_r      <= TAG_NONE;
      ill0_r      <= 1'b0;
      if (in_display) begin
        mem_en_r   <= 1'b1;
        mem_addr_r <= disp_addr_s;
        tag0_r     <= TAG_DISP;
      end else if (clear_busy_r) begin
        mem_en_r   <= 1'b1;
        mem_we_r   <= 1'b1;
        mem_addr_r <= clear_ptr_r;
      end else if (accept_s) begin
        if (legal_s) begin
          mem_en_r    <= 1'b1;
          mem_we_r    <= req_we;
          mem_addr_r  <= req_addr;
          mem_wdata_r <= req_wdata;
        end else begin
          ill0_r <= 1'b1;
        end
        tag0_r <= req_we ? TAG_NONE : TAG_GAME;
      end

      tag1_r    <= tag0_r;
      ill1_r    <= ill0_r;
      req_err_r <= ill0_r;

      pixel_valid_r <= (tag1_r == TAG_DISP);
      pixel_cell_r  <= (tag1_r == TAG_DISP) ? mem_rdata : EMPTY;
      rsp_valid_r   <= (tag1_r == TAG_GAME);
      rsp_rdata_r   <= ((tag1_r == TAG_GAME) && !ill1_r) ? mem_rdata : EMPTY;
    end
  end

  assign mem_en      = mem_en_r;
  assign mem_we      = mem_we_r;
  assign mem_addr    = mem_addr_r;
  assign mem_wdata   = mem_wdata_r;
  assign pixel_valid = pixel_valid_r;
  assign pixel_cell  = pixel_cell_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_rdata   = rsp_rdata_r;
  assign req_err     = req_err_r;
  assign clear_busy  = clear_busy_r;
  assign clear_done  = clear_done_r;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Directed bench for board_mem_arbiter with a behavioural single-port RAM.
module tb_board_mem_arbiter;

  logic       clock;
  logic       reset;
  logic       in_display;
  logic [9:0] count_x;
  logic [9:0] count_y;
  logic [2:0] pixel_cell;
  logic       pixel_valid;
  logic       req_valid;
  logic       req_we;
  logic [7:0] req_addr;
  logic [2:0] req_wdata;
  logic       req_ready;
  logic       rsp_valid;
  logic [2:0] rsp_rdata;
  logic       req_err;
  logic       clear_start;
  logic       clear_busy;
  logic       clear_done;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [2:0] mem_wdata;
  logic [2:0] mem_rdata;

  logic [2:0]  ram [0:255];
  logic [23:0] outs_s;

  int vectors = 0;
  int errors  = 0;

  board_mem_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .in_display  (in_display),
    .count_x     (count_x),
    .count_y     (count_y),
    .pixel_cell  (pixel_cell),
    .pixel_valid (pixel_valid),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .req_err     (req_err),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  assign outs_s = {pixel_cell, pixel_valid, rsp_valid, rsp_rdata, req_err,
                   clear_busy, clear_done, mem_en, mem_we, mem_addr, mem_wdata};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single-port synchronous RAM; read data holds when not enabled.
  always @(posedge clock) begin
    if (mem_en === 1'b1) begin
      if (mem_we === 1'b1) ram[mem_addr] <= mem_wdata;
      else                 mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic game_write(input logic [7:0] a, input logic [2:0] d);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    step;
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step; step;
    vectors++;
    if (outs_s !== 24'd0) begin errors++; $display("FAIL reset_outs: got %h want 000000", outs_s); end
    vectors++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    reset = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b want 1", req_ready); end
  endtask

  task automatic test_display;
    logic [9:0] xs [4];
    logic [9:0] ys [4];
    logic [7:0] ea [4];
    logic [2:0] ec [4];
    xs = '{10'd3, 10'd9, 10'd0, 10'd10};
    ys = '{10'd1, 10'd19, 10'd0, 10'd25};
    ea = '{8'd13, 8'd199, 8'd0, 8'd4};
    ec = '{3'd5, 3'd3, 3'd7, 3'd2};
    for (int k = 0; k < 4; k++) game_write(ea[k], ec[k]);
    step;
    for (int k = 0; k < 4; k++) begin
      in_display = 1'b1; count_x = xs[k]; count_y = ys[k];
      step;
      in_display = 1'b0;
      vectors++;
      if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, ea[k]}) begin
        errors++; $display("FAIL disp_issue[%0d]: got en=%b we=%b addr=%0d want en=1 we=0 addr=%0d", k, mem_en, mem_we, mem_addr, ea[k]);
      end
      step; step;
      vectors++;
      if ({pixel_valid, pixel_cell} !== {1'b1, ec[k]}) begin
        errors++; $display("FAIL disp_pixel[%0d]: got valid=%b cell=%0d want valid=1 cell=%0d", k, pixel_valid, pixel_cell, ec[k]);
      end
      step;
      vectors++;
      if ({pixel_valid, pixel_cell} !== 4'd0) begin
        errors++; $display("FAIL disp_blank[%0d]: got valid=%b cell=%0d want 0/0", k, pixel_valid, pixel_cell);
      end
    end
  endtask

  task automatic test_game_rw;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'd42; req_wdata = 3'd6;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b want 1", req_ready); end
    step;
    vectors++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 8'd42, 3'd6}) begin
      errors++; $display("FAIL wr_issue: got en=%b we=%b addr=%0d data=%0d want 1/1/42/6", mem_en, mem_we, mem_addr, mem_wdata);
    end
    req_we = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rd_ready: got %b want 1", req_ready); end
    step;
    req_valid = 1'b0;
    vectors++;
    if ({mem_en, mem_we, mem_addr, rsp_valid} !== {1'b1, 1'b0, 8'd42, 1'b0}) begin
      errors++; $display("FAIL rd_issue: got en=%b we=%b addr=%0d rsp=%b want 1/0/42/0", mem_en, mem_we, mem_addr, rsp_valid);
    end
    step;
    vectors++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_early: got rsp_valid=%b want 0", rsp_valid); end
    step;
    vectors++;
    if ({rsp_valid, rsp_rdata} !== {1'b1, 3'd6}) begin
      errors++; $display("FAIL rd_rsp: got valid=%b data=%0d want 1/6", rsp_valid, rsp_rdata);
    end
    step;
    vectors++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_pulse: got rsp_valid=%b want 0", rsp_valid); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] a [3];
    logic [2:0] d [3];
    a = '{8'd13, 8'd42, 8'd199};
    d = '{3'd5, 3'd6, 3'd3};
    for (int k = 0; k < 6; k++) begin
      req_valid = (k < 3); req_we = 1'b0; req_addr = (k < 3) ? a[k] : 8'd0;
      step;
      if (k >= 2 && k < 5) begin
        vectors++;
        if ({rsp_valid, rsp_rdata} !== {1'b1, d[k-2]}) begin
          errors++; $display("FAIL b2b_rsp[%0d]: got valid=%b data=%0d want 1/%0d", k - 2, rsp_valid, rsp_rdata, d[k-2]);
        end
      end else if (k == 5) begin
        vectors++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_end: got rsp_valid=%b want 0", rsp_valid); end
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_display_hold;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd42;
    for (int k = 0; k < 2; k++) begin
      in_display = 1'b1; count_x = 10'(5 + k); count_y = 10'd2;
      #1;
      vectors++;
      if (req_ready !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d]: got %b want 0", k, req_ready); end
      step;
      vectors++;
      if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 8'(25 + k)}) begin
        errors++; $display("FAIL hold_slot[%0d]: got en=%b we=%b addr=%0d want 1/0/%0d", k, mem_en, mem_we, mem_addr, 25 + k);
      end
    end
    in_display = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL hold_release: got ready=%b want 1", req_ready); end
    step;
    req_valid = 1'b0;
    vectors++;
    if ({mem_en, mem_we, mem_addr, rsp_valid} !== {1'b1, 1'b0, 8'd42, 1'b0}) begin
      errors++; $display("FAIL hold_issue: got en=%b we=%b addr=%0d rsp=%b want 1/0/42/0", mem_en, mem_we, mem_addr, rsp_valid);
    end
    step; step;
    vectors++;
    if ({rsp_valid, rsp_rdata} !== {1'b1, 3'd6}) begin
      errors++; $display("FAIL hold_rsp: got valid=%b data=%0d want 1/6", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_illegal;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd42;
    step;
    req_addr = 8'd200;
    step;
    vectors++;
    if ({mem_en, req_err} !== 2'b00) begin errors++; $display("FAIL ill_rd_slot: got en=%b err=%b want 0/0", mem_en, req_err); end
    req_we = 1'b1; req_addr = 8'd255; req_wdata = 3'd5;
    step;
    req_valid = 1'b0; req_we = 1'b0;
    vectors++;
    if ({rsp_valid, rsp_rdata, req_err, mem_en} !== {1'b1, 3'd6, 1'b1, 1'b0}) begin
      errors++; $display("FAIL ill_rd_err: got rsp=%b data=%0d err=%b en=%b want 1/6/1/0", rsp_valid, rsp_rdata, req_err, mem_en);
    end
    step;
    vectors++;
    if ({rsp_valid, rsp_rdata, req_err} !== {1'b1, 3'd0, 1'b1}) begin
      errors++; $display("FAIL ill_rd_rsp: got rsp=%b data=%0d err=%b want 1/0/1", rsp_valid, rsp_rdata, req_err);
    end
    step;
    vectors++;
    if ({rsp_valid, req_err} !== 2'b00) begin
      errors++; $display("FAIL ill_wr_end: got rsp=%b err=%b want 0/0", rsp_valid, req_err);
    end
  endtask

  task automatic test_clear_sweep;
    int  wcount = 0, bad = 0, done_cnt = 0, done_wcount = -1, busy_bad = 0, ready_bad = 0;
    int  tail = 0, rcnt = 0, zbad = 0;
    logic finished = 1'b0, pend = 1'b0, disp_at_edge;
    for (int i = 0; i < 200; i++) game_write(8'(i), 3'((i % 7) + 1));
    clear_start = 1'b1;
    step;
    clear_start = 1'b0;
    vectors++;
    if (clear_busy !== 1'b1) begin errors++; $display("FAIL clr_busy_start: got %b want 1", clear_busy); end
    for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
      in_display  = ((cyc % 18) >= 8);
      clear_start = (cyc == 100) || pend;
      pend = 1'b0;
      #1;
      if (clear_busy === 1'b1 && !in_display && req_ready !== 1'b0) ready_bad++;
      disp_at_edge = in_display;
      step;
      clear_start = 1'b0;
      if (mem_en === 1'b1 && mem_we === 1'b1) begin
        if (disp_at_edge || mem_addr !== wcount[7:0] || mem_wdata !== 3'd0) bad++;
        wcount++;
      end else if (mem_en === 1'b1 && !disp_at_edge) begin
        bad++;
      end
      if (clear_done === 1'b1) begin
        done_cnt++;
        done_wcount = wcount;
        pend = (done_cnt == 1);
      end
      if (done_cnt == 0 && clear_busy !== 1'b1) busy_bad++;
      if (done_cnt > 0 && clear_busy !== 1'b0) busy_bad++;
      if (done_cnt > 0) tail++;
      if (tail >= 40) finished = 1'b1;
    end
    in_display = 1'b0;
    vectors++;
    if (finished !== 1'b1) begin errors++; $display("FAIL clr_timeout: got no clear_done within budget, want done"); end
    vectors++;
    if (wcount != 200) begin errors++; $display("FAIL clr_writes: got %0d want 200", wcount); end
    vectors++;
    if (bad != 0) begin errors++; $display("FAIL clr_write_slots: got %0d bad accesses want 0", bad); end
    vectors++;
    if (done_cnt != 1 || done_wcount != 200) begin
      errors++; $display("FAIL clr_done: got %0d pulses after %0d writes want 1 after 200", done_cnt, done_wcount);
    end
    vectors++;
    if (busy_bad != 0) begin errors++; $display("FAIL clr_busy: got %0d bad cycles want 0", busy_bad); end
    vectors++;
    if (ready_bad != 0) begin errors++; $display("FAIL clr_ready: got %0d ready cycles while busy want 0", ready_bad); end
    for (int i = 0; i < 204; i++) begin
      req_valid = (i < 200); req_we = 1'b0; req_addr = 8'(i);
      step;
      if (rsp_valid === 1'b1) begin
        if (rsp_rdata !== 3'd0) zbad++;
        rcnt++;
      end
    end
    req_valid = 1'b0;
    vectors++;
    if (rcnt != 200 || zbad != 0) begin
      errors++; $display("FAIL clr_readback: got %0d responses %0d nonzero want 200 responses 0 nonzero", rcnt, zbad);
    end
  endtask

  task automatic test_reset_mid_clear;
    int  wc = 0, bad = 0;
    logic seen = 1'b0;
    in_display = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'd7; req_wdata = 3'd3; clear_start = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL start_req_ready: got %b want 1", req_ready); end
    step;
    req_valid = 1'b0; req_we = 1'b0; clear_start = 1'b0;
    vectors++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, clear_busy} !== {1'b1, 1'b1, 8'd7, 3'd3, 1'b1}) begin
      errors++; $display("FAIL start_with_req: got en=%b we=%b addr=%0d data=%0d busy=%b want 1/1/7/3/1", mem_en, mem_we, mem_addr, mem_wdata, clear_busy);
    end
    for (int cyc = 0; cyc < 500 && wc < 50; cyc++) begin
      in_display = ((cyc % 18) >= 8);
      step;
      if (cyc == 0) begin
        vectors++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 8'd0, 3'd0}) begin
          errors++; $display("FAIL first_clear_write: got en=%b we=%b addr=%0d data=%0d want 1/1/0/0", mem_en, mem_we, mem_addr, mem_wdata);
        end
      end
      if (mem_en === 1'b1 && mem_we === 1'b1) wc++;
    end
    in_display = 1'b0;
    reset = 1'b1;
    step;
    vectors++;
    if (outs_s !== 24'd0 || req_ready !== 1'b0 || wc != 50) begin
      errors++; $display("FAIL midclear_reset: got outs=%h ready=%b writes=%0d want 000000/0/50", outs_s, req_ready, wc);
    end
    reset = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      step;
      if (clear_done !== 1'b0 || mem_en !== 1'b0 || clear_busy !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin errors++; $display("FAIL midclear_aborted: got %0d active cycles want 0", bad); end
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd150;
    step;
    req_valid = 1'b0;
    reset = 1'b1;
    step;
    vectors++;
    if (outs_s !== 24'd0) begin errors++; $display("FAIL inflight_reset: got %h want 000000", outs_s); end
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step;
      if (rsp_valid !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin errors++; $display("FAIL inflight_dropped: got rsp_valid after reset, want none"); end
  endtask

  initial begin
    reset = 1'b1; in_display = 1'b0; count_x = 10'd0; count_y = 10'd0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 8'd0; req_wdata = 3'd0; clear_start = 1'b0;
    test_reset;
    test_display;
    test_game_rw;
    test_back_to_back;
    test_display_hold;
    test_illegal;
    test_clear_sweep;
    test_reset_mid_clear;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
